// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush controller: merges stall sources into hold_flag_o and sequences timed holds and jump flush bubbles.
// Latency: level holds and the jump redirect are combinational; timed/flush holds start one cycle after the sampling edge.
// Backpressure: none; requests that arrive during an active timed/flush hold are dropped. Macro PIPE_CTRL_TIMED_HOLD_EN builds the TIMED state.
module pipe_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             jump_flag_i,
   input  logic [31:0]      jump_addr_i,
   input  logic             hold_flag_ex_i,
   input  logic             hold_flag_clint_i,
   input  logic             hold_flag_rib_i,
   input  logic             timed_hold_req_i,
   input  logic [CNT_W-1:0] timed_hold_len_i,
   output logic [2:0]       hold_flag_o,
   output logic             jump_flag_o,
   output logic [31:0]      jump_addr_o,
   output logic             timed_hold_busy_o,
   output logic [31:0]      stall_cnt_o
);

   // Hold levels; Hold_If (2) exists in the encoding but no source here uses it.
   localparam logic [2:0] HOLD_NONE = 3'd0;
   localparam logic [2:0] HOLD_PC   = 3'd1;
   localparam logic [2:0] HOLD_ID   = 3'd3;

   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TIMED = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [31:0]      stall_cnt;

`ifndef PIPE_CTRL_TIMED_HOLD_EN
   // Timed-hold request ports stay on the boundary but have no effect in this build.
   logic unused_timed_hold;
   assign unused_timed_hold = timed_hold_req_i ^ (^timed_hold_len_i);
`endif

   // State register: synchronous reset abandons any hold in progress.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state: a jump always wins and reloads the flush; otherwise count down or accept a new timed hold.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (jump_flag_i) begin
         if (FLUSH_CYCLES > 0) begin
            state_nxt = ST_FLUSH;
            cnt_nxt   = FLUSH_LOAD;
         end else begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
`ifdef PIPE_CTRL_TIMED_HOLD_EN
               if (timed_hold_req_i && (timed_hold_len_i != '0)) begin
                  state_nxt = ST_TIMED;
                  cnt_nxt   = timed_hold_len_i;
               end
`endif
            end
            ST_TIMED, ST_FLUSH: begin
               // Requests arriving here are deliberately dropped, not queued.
               if (cnt == CNT_ONE) begin
                  state_nxt = ST_IDLE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt - CNT_ONE;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Outputs: maximum of active hold levels plus redirect, all forced to zero while in reset.
   always_comb begin
      hold_flag_o       = HOLD_NONE;
      jump_flag_o       = 1'b0;
      jump_addr_o       = '0;
      timed_hold_busy_o = 1'b0;
      if (rst) begin
         if (hold_flag_rib_i) begin
            hold_flag_o = HOLD_PC;
         end
         if (jump_flag_i || hold_flag_ex_i || hold_flag_clint_i || (state != ST_IDLE)) begin
            hold_flag_o = HOLD_ID;
         end
         jump_flag_o = jump_flag_i;
         if (jump_flag_i) begin
            jump_addr_o = jump_addr_i;
         end
`ifdef PIPE_CTRL_TIMED_HOLD_EN
         timed_hold_busy_o = (state == ST_TIMED);
`endif
      end
   end

   // Stall statistics: count every cycle the pipeline is held at any level; wraps naturally.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (hold_flag_o != HOLD_NONE) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random traffic against a hold-counting reference model.
// Latency: expected values are pushed when inputs are driven and popped by the monitor on the falling edge.
// Backpressure: none; the monitor consumes one expectation per cycle.
module tb_pipe_ctrl;

   localparam int FLUSH_CYCLES = 1;
   localparam int CNT_W        = 3;
`ifdef PIPE_CTRL_TIMED_HOLD_EN
   localparam bit TIMED_EN = 1'b1;
`else
   localparam bit TIMED_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             jump_flag_i;
   logic [31:0]      jump_addr_i;
   logic             hold_flag_ex_i;
   logic             hold_flag_clint_i;
   logic             hold_flag_rib_i;
   logic             timed_hold_req_i;
   logic [CNT_W-1:0] timed_hold_len_i;
   logic [2:0]       hold_flag_o;
   logic             jump_flag_o;
   logic [31:0]      jump_addr_o;
   logic             timed_hold_busy_o;
   logic [31:0]      stall_cnt_o;

   pipe_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
      .clk               (clk),
      .rst               (rst),
      .jump_flag_i       (jump_flag_i),
      .jump_addr_i       (jump_addr_i),
      .hold_flag_ex_i    (hold_flag_ex_i),
      .hold_flag_clint_i (hold_flag_clint_i),
      .hold_flag_rib_i   (hold_flag_rib_i),
      .timed_hold_req_i  (timed_hold_req_i),
      .timed_hold_len_i  (timed_hold_len_i),
      .hold_flag_o       (hold_flag_o),
      .jump_flag_o       (jump_flag_o),
      .jump_addr_o       (jump_addr_o),
      .timed_hold_busy_o (timed_hold_busy_o),
      .stall_cnt_o       (stall_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  hold;
      logic        jf;
      logic [31:0] ja;
      logic        busy;
      logic [31:0] stall;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: remaining cycles of each kind of hold and the stall total.
   int          m_flush = 0;
   int          m_timed = 0;
   logic [31:0] m_stall = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Monitor: one expectation per cycle, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("hold_flag", 32'(hold_flag_o), 32'(e.hold));
            check("jump_flag", 32'(jump_flag_o), 32'(e.jf));
            check("jump_addr", jump_addr_o, e.ja);
            check("busy", 32'(timed_hold_busy_o), 32'(e.busy));
            check("stall_cnt", stall_cnt_o, e.stall);
         end
      end
   end

   // Drive one cycle of inputs (called just after a rising edge), predict outputs, then advance the model.
   task automatic drive(input bit r, input bit jf, input logic [31:0] ja, input bit ex,
                        input bit clint, input bit rib, input bit req, input logic [CNT_W-1:0] len);
      exp_t e;
      rst = r; jump_flag_i = jf; jump_addr_i = ja; hold_flag_ex_i = ex;
      hold_flag_clint_i = clint; hold_flag_rib_i = rib;
      timed_hold_req_i = req; timed_hold_len_i = len;
      e.stall = m_stall;
      if (!r) begin
         e.hold = 3'd0; e.jf = 1'b0; e.ja = '0; e.busy = 1'b0;
      end else begin
         e.hold = 3'd0;
         if (rib) e.hold = 3'd1;
         if (jf || ex || clint || m_flush > 0 || m_timed > 0) e.hold = 3'd3;
         e.jf   = jf;
         e.ja   = jf ? ja : 32'd0;
         e.busy = (m_timed > 0);
      end
      sb_q.push_back(e);
      @(posedge clk);
      if (!r) begin
         m_flush = 0; m_timed = 0; m_stall = '0;
      end else begin
         if (e.hold != 3'd0) m_stall = m_stall + 32'd1;
         if (jf) begin
            m_flush = FLUSH_CYCLES; m_timed = 0;
         end else if (m_flush > 0) begin
            m_flush--;
         end else if (m_timed > 0) begin
            m_timed--;
         end else if (TIMED_EN && req && len != '0) begin
            m_timed = int'(len);
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1, 0, $urandom, 0, 0, 0, 0, 3'd0);
   endtask

   initial begin
      // Reset with every request high.
      rst = 0; jump_flag_i = 1; jump_addr_i = 32'hDEAD_BEEF; hold_flag_ex_i = 1;
      hold_flag_clint_i = 1; hold_flag_rib_i = 1; timed_hold_req_i = 1; timed_hold_len_i = 3'd5;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) drive(0, 1, 32'hDEAD_BEEF, 1, 1, 1, 1, 3'd5);
      idle(2);

      // Jump with a one-cycle flush bubble.
      drive(1, 1, 32'h0000_0100, 0, 0, 0, 0, 3'd0);
      idle(3);
      check("stall_after_jump", stall_cnt_o, 32'd2);

      // Timed hold len=3, second request mid-hold is dropped.
      drive(1, 0, 0, 0, 0, 0, 1, 3'd3);
      drive(1, 0, 0, 0, 0, 0, 0, 3'd0);
      drive(1, 0, 0, 0, 0, 0, 1, 3'd5);
      idle(6);

      // Jump in cycle 2 of a len=7 hold aborts it.
      drive(1, 0, 0, 0, 0, 0, 1, 3'd7);
      idle(1);
      drive(1, 1, 32'h0000_2000, 0, 0, 0, 0, 3'd0);
      idle(5);

      // Level merge.
      drive(1, 0, 0, 0, 0, 1, 0, 3'd0);
      drive(1, 0, 0, 1, 0, 1, 0, 3'd0);
      drive(1, 0, 0, 0, 0, 1, 0, 3'd0);
      drive(1, 0, 0, 0, 1, 0, 0, 3'd0);
      idle(1);

      // Zero-length request ignored; len=4 request (no-op when timed holds are not built).
      drive(1, 0, 0, 0, 0, 0, 1, 3'd0);
      idle(1);
      drive(1, 0, 0, 0, 0, 0, 1, 3'd4);
      idle(6);

      // Reset in the middle of a timed hold and of a flush.
      drive(1, 0, 0, 0, 0, 0, 1, 3'd6);
      idle(2);
      drive(0, 0, 0, 0, 0, 0, 0, 3'd0);
      idle(3);
      drive(1, 1, 32'h0000_0400, 0, 0, 0, 0, 3'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 3'd0);
      idle(3);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 59) != 0),
               ($urandom_range(0, 7) == 0),
               $urandom,
               ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 11) == 0),
               ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 3) == 0),
               CNT_W'($urandom_range(0, 7)));
      end
      idle(2);

      // All expectations must have been consumed by the monitor.
      @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
